rr_bus_arbiter: RTL

- Round-robin arbiter that shares one DATA_W-bit output bus among N_REQ requesters.
- Registered FSM picks the owner. The output mux drives the owner's data when a grant is active and drives all zeros otherwise, so the output is latch-free by construction.
- Sits between several producer blocks (lab peripherals, pattern generators) and a single consumer, such as an LED/7-seg driver or a UART TX byte path.

---
 rtl/rr_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_bus_arbiter
// Description : Round-robin arbiter that shares one DATA_W-bit output bus
//               among N_REQ requesters. A registered two-state FSM picks the
//               owner, and each owner may hold the bus for at most MAX_HOLD
//               consecutive cycles. o_y carries the owner's data while a
//               grant is active and is zero otherwise.
//               Optional feature macro: RR_ARB_STATS_EN adds o_grant_cnt, a
//               saturating 16-bit count of arbitration wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_W-1:0]    i_data,
  output logic [N_REQ-1:0]           o_gnt,
  output logic                       o_valid,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic [DATA_W-1:0]          o_y
`ifdef RR_ARB_STATS_EN
  ,
  output logic [15:0]                o_grant_cnt
`endif
);

  localparam int                 c_own_w     = $clog2(N_REQ);
  localparam logic [7:0]         c_hold_last = 8'(MAX_HOLD - 1);
  // Pointer starts at the last index so requester 0 is searched first.
  localparam logic [c_own_w-1:0] c_ptr_rst   = c_own_w'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [c_own_w-1:0]   owner_q, owner_d;
  logic [c_own_w-1:0]   ptr_q, ptr_d;
  logic [7:0]           hold_q, hold_d;

  logic [c_own_w:0]     w_pick;
  logic                 w_pick_found;
  logic [c_own_w-1:0]   w_pick_idx;
  logic                 w_release;
  logic [DATA_W-1:0]    w_slice [N_REQ];

  // Returns {found, index} of the first requester in round-robin order,
  // starting after 'last' and considering 'last' itself at the very end.
  // The loop walks from the farthest candidate to the nearest so that the
  // nearest set bit is the one left in the result.
  function automatic logic [c_own_w:0] rr_pick(input logic [N_REQ-1:0]   req,
                                               input logic [c_own_w-1:0] last);
    logic [c_own_w:0]   res;
    logic [c_own_w-1:0] cand_idx;
    int                 cand;
    res = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand     = (int'(last) + i) % N_REQ;
      cand_idx = cand[c_own_w-1:0];
      if (req[cand_idx]) begin
        res = {1'b1, cand_idx};
      end
    end
    return res;
  endfunction

  // Split the packed data bus into one word per requester.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_slice[k] = i_data[k*DATA_W +: DATA_W];
  end

  assign w_pick       = rr_pick(i_req, ptr_q);
  assign w_pick_found = w_pick[c_own_w];
  assign w_pick_idx   = w_pick[c_own_w-1:0];

  // The owner gives up the bus when it stops requesting or has used its
  // full MAX_HOLD-cycle slot.
  assign w_release = (state_q == ST_GRANT) &&
                     (!i_req[owner_q] || (hold_q == c_hold_last));

  // Next-state, owner, pointer, hold counter and grant vector.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          state_d = ST_GRANT;
          owner_d = w_pick_idx;
          ptr_d   = w_pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + 8'd1;
        if (w_release) begin
          if (w_pick_found) begin
            // Direct handover (or timeout re-grant) without an idle gap.
            owner_d = w_pick_idx;
            ptr_d   = w_pick_idx;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    if (state_d == ST_GRANT) begin
      gnt_d[owner_d] = 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= c_ptr_rst;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Shared bus mux: zero by default, owner's live data only while granted.
  always_comb begin
    o_y = '0;
    if (state_q == ST_GRANT) begin
      o_y = w_slice[owner_q];
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = (state_q == ST_GRANT);
  assign o_owner = owner_q;

`ifdef RR_ARB_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic        w_win;

  // A win is any edge that installs an owner: from IDLE, or a handover
  // (including a timeout re-grant of the same requester) from GRANT.
  assign w_win = ((state_q == ST_IDLE) && w_pick_found) ||
                 (w_release && w_pick_found);

  // Saturating win counter update.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (w_win && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  // Win counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign o_grant_cnt = grant_cnt_q;
`endif

endmodule
`default_nettype wire
